hazard_pipe_regs: RTL and testbench

Front-end pipeline register block for the 5-stage pipeline: PC register, IF/ID register and ID/EX register, acting on the load-use stall controls (PC_WriteEn, IFID_WriteEn, Stall_flush) and on EX-stage branch redirects. It is the responder to the stall controller. It produces the EX_MemRead/EX_rt and ID_rs/ID_rt/ID_Op fields that the controller consumes, and it applies the hold and bubble actions the controller requests. Saturating stall and flush counters are included for performance debug.

---
 rtl/hazard_pipe_regs_if.sv | 51 +++++
 rtl/hazard_pipe_regs.sv | 110 +++++++++++
 tb/tb_hazard_pipe_regs.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/hazard_pipe_regs_if.sv
// Bundle between the stall controller / fetch / decode and the
// front-end pipeline registers (PC, IF/ID, ID/EX).
interface hazard_pipe_regs_if #(
  parameter int CNT_W = 16
);
  logic             PC_WriteEn;
  logic             IFID_WriteEn;
  logic             Stall_flush;
  logic             Branch_taken;
  logic [31:0]      Branch_target;
  logic [31:0]      IF_Instr;
  logic             ID_MemRead;
  logic             ID_MemWrite;
  logic             ID_RegWrite;
  logic [4:0]       ID_rd;
  logic [31:0]      PC;
  logic [31:0]      ID_Instr;
  logic [31:0]      ID_PCPlus4;
  logic             ID_Valid;
  logic [5:0]       ID_Op;
  logic [4:0]       ID_rs;
  logic [4:0]       ID_rt;
  logic             EX_MemRead;
  logic             EX_MemWrite;
  logic             EX_RegWrite;
  logic             EX_Valid;
  logic [4:0]       EX_rt;
  logic [4:0]       EX_rd;
  logic [CNT_W-1:0] Stall_count;
  logic [CNT_W-1:0] Flush_count;

  modport master (
    output PC_WriteEn, IFID_WriteEn, Stall_flush,
    output Branch_taken, Branch_target, IF_Instr,
    output ID_MemRead, ID_MemWrite, ID_RegWrite, ID_rd,
    input  PC, ID_Instr, ID_PCPlus4, ID_Valid,
    input  ID_Op, ID_rs, ID_rt,
    input  EX_MemRead, EX_MemWrite, EX_RegWrite, EX_Valid,
    input  EX_rt, EX_rd, Stall_count, Flush_count
  );

  modport slave (
    input  PC_WriteEn, IFID_WriteEn, Stall_flush,
    input  Branch_taken, Branch_target, IF_Instr,
    input  ID_MemRead, ID_MemWrite, ID_RegWrite, ID_rd,
    output PC, ID_Instr, ID_PCPlus4, ID_Valid,
    output ID_Op, ID_rs, ID_rt,
    output EX_MemRead, EX_MemWrite, EX_RegWrite, EX_Valid,
    output EX_rt, EX_rd, Stall_count, Flush_count
  );
endinterface

// File: rtl/hazard_pipe_regs.sv
// Front-end pipeline registers: PC, IF/ID and ID/EX with load-use
// hold/bubble handling, branch redirect and saturating debug counters.
module hazard_pipe_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input logic              clk,
  input logic              rst,
  hazard_pipe_regs_if.slave bus
);

  logic [31:0]      r_pc;
  logic [31:0]      r_id_instr;
  logic [31:0]      r_id_pc4;
  logic             r_id_valid;
  logic             r_ex_mem_read;
  logic             r_ex_mem_write;
  logic             r_ex_reg_write;
  logic             r_ex_valid;
  logic [4:0]       r_ex_rt;
  logic [4:0]       r_ex_rd;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [31:0]      w_pc_plus4;
  logic [4:0]       w_id_rt;
  logic             w_ex_bubble;
  logic             w_stall_evt;

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_id_rt     = r_id_instr[20:16];
  assign w_ex_bubble = bus.Branch_taken | bus.Stall_flush;
  // A stall cycle that coincides with a redirect counts as a flush only.
  assign w_stall_evt = bus.Stall_flush & ~bus.Branch_taken;

  // PC: redirect beats the stall hold; otherwise step by 4 (wraps).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (bus.Branch_taken) begin
      r_pc <= bus.Branch_target;
    end else if (bus.PC_WriteEn) begin
      r_pc <= w_pc_plus4;
    end
  end

  // IF/ID: squash on redirect, capture fetch when enabled, else hold.
  always_ff @(posedge clk) begin
    if (rst || bus.Branch_taken) begin
      r_id_instr <= 32'd0;
      r_id_pc4   <= 32'd0;
      r_id_valid <= 1'b0;
    end else if (bus.IFID_WriteEn) begin
      r_id_instr <= bus.IF_Instr;
      r_id_pc4   <= w_pc_plus4;
      r_id_valid <= 1'b1;
    end
  end

  // ID/EX: bubble on redirect or stall, otherwise advance from ID.
  always_ff @(posedge clk) begin
    if (rst || w_ex_bubble) begin
      r_ex_mem_read  <= 1'b0;
      r_ex_mem_write <= 1'b0;
      r_ex_reg_write <= 1'b0;
      r_ex_valid     <= 1'b0;
      r_ex_rt        <= 5'd0;
      r_ex_rd        <= 5'd0;
    end else begin
      r_ex_mem_read  <= bus.ID_MemRead;
      r_ex_mem_write <= bus.ID_MemWrite;
      r_ex_reg_write <= bus.ID_RegWrite;
      r_ex_valid     <= r_id_valid;
      r_ex_rt        <= w_id_rt;
      r_ex_rd        <= bus.ID_rd;
    end
  end

  // Saturating stall/flush event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (bus.Branch_taken && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.PC          = r_pc;
  assign bus.ID_Instr    = r_id_instr;
  assign bus.ID_PCPlus4  = r_id_pc4;
  assign bus.ID_Valid    = r_id_valid;
  assign bus.ID_Op       = r_id_instr[31:26];
  assign bus.ID_rs       = r_id_instr[25:21];
  assign bus.ID_rt       = w_id_rt;
  assign bus.EX_MemRead  = r_ex_mem_read;
  assign bus.EX_MemWrite = r_ex_mem_write;
  assign bus.EX_RegWrite = r_ex_reg_write;
  assign bus.EX_Valid    = r_ex_valid;
  assign bus.EX_rt       = r_ex_rt;
  assign bus.EX_rd       = r_ex_rd;
  assign bus.Stall_count = r_stall_cnt;
  assign bus.Flush_count = r_flush_cnt;

endmodule

// File: tb/tb_hazard_pipe_regs.sv
// Scoreboard bench for hazard_pipe_regs: directed vectors push expected
// register state, a monitor pops and compares after each clock edge.
module tb_hazard_pipe_regs;

  localparam int CW = 4;

  logic clk;
  logic rst;

  hazard_pipe_regs_if #(.CNT_W(CW)) bus ();

  hazard_pipe_regs #(
    .RESET_PC (32'h0000_0400),
    .CNT_W    (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        pcwe;
    logic        ifwe;
    logic        sf;
    logic        bt;
    logic [31:0] tgt;
    logic [31:0] instr;
    logic        mr;
    logic        mw;
    logic        rw;
    logic [4:0]  rd;
  } stim_t;

  typedef struct packed {
    logic [31:0]   pc;
    logic [31:0]   ii;
    logic [31:0]   p4;
    logic          iv;
    logic          emr;
    logic          emw;
    logic          erw;
    logic [4:0]    ert;
    logic [4:0]    erd;
    logic          ev;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  localparam logic [31:0] I1 = 32'h8C25_0000;
  localparam logic [31:0] I2 = 32'h00A7_3020;
  localparam logic [31:0] I3 = 32'h2108_0001;
  localparam logic [31:0] I4 = 32'h3C0A_1234;

  exp_t q[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp, input int vec);
    n_tot++;
    if (act !== exp)
      $display("FAIL v%0d %s: got %h want %h", vec, nm, act, exp);
    else
      n_pass++;
  endtask

  int vidx = 0;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      vidx++;
      chk("PC", bus.PC, e.pc, vidx);
      chk("ID_Instr", bus.ID_Instr, e.ii, vidx);
      chk("ID_PCPlus4", bus.ID_PCPlus4, e.p4, vidx);
      chk("ID_Valid", 32'(bus.ID_Valid), 32'(e.iv), vidx);
      chk("ID_Op", 32'(bus.ID_Op), 32'(e.ii[31:26]), vidx);
      chk("ID_rs", 32'(bus.ID_rs), 32'(e.ii[25:21]), vidx);
      chk("ID_rt", 32'(bus.ID_rt), 32'(e.ii[20:16]), vidx);
      chk("EX_MemRead", 32'(bus.EX_MemRead), 32'(e.emr), vidx);
      chk("EX_MemWrite", 32'(bus.EX_MemWrite), 32'(e.emw), vidx);
      chk("EX_RegWrite", 32'(bus.EX_RegWrite), 32'(e.erw), vidx);
      chk("EX_rt", 32'(bus.EX_rt), 32'(e.ert), vidx);
      chk("EX_rd", 32'(bus.EX_rd), 32'(e.erd), vidx);
      chk("EX_Valid", 32'(bus.EX_Valid), 32'(e.ev), vidx);
      chk("Stall_count", 32'(bus.Stall_count), 32'(e.sc), vidx);
      chk("Flush_count", 32'(bus.Flush_count), 32'(e.fc), vidx);
    end
  end

  task automatic step(input stim_t s, input exp_t e);
    rst               = s.rst;
    bus.PC_WriteEn    = s.pcwe;
    bus.IFID_WriteEn  = s.ifwe;
    bus.Stall_flush   = s.sf;
    bus.Branch_taken  = s.bt;
    bus.Branch_target = s.tgt;
    bus.IF_Instr      = s.instr;
    bus.ID_MemRead    = s.mr;
    bus.ID_MemWrite   = s.mw;
    bus.ID_RegWrite   = s.rw;
    bus.ID_rd         = s.rd;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    exp_t rst_e;
    exp_t e;
    rst_e = '{32'h400, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0,
              5'd0, 5'd0, 1'b0, 4'd0, 4'd0};

    // reset held for two cycles
    step('{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,I1,1'b0,1'b0,1'b0,5'd0}, rst_e);
    step('{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,I1,1'b0,1'b0,1'b0,5'd0}, rst_e);
    // fetch lw $5 at 0x400
    step('{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,I1,1'b0,1'b0,1'b0,5'd0},
         '{32'h404,I1,32'h404,1'b1,1'b0,1'b0,1'b0,5'd0,5'd0,1'b0,4'd0,4'd0});
    // lw moves to EX, add fetched
    step('{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,I2,1'b1,1'b0,1'b1,5'd5},
         '{32'h408,I2,32'h408,1'b1,1'b1,1'b0,1'b1,5'd5,5'd5,1'b1,4'd0,4'd0});
    // load-use stall: hold PC and IF/ID, bubble into EX
    step('{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,I3,1'b0,1'b0,1'b1,5'd6},
         '{32'h408,I2,32'h408,1'b1,1'b0,1'b0,1'b0,5'd0,5'd0,1'b0,4'd1,4'd0});
    // release: held add enters EX
    step('{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,I3,1'b0,1'b0,1'b1,5'd6},
         '{32'h40C,I3,32'h40C,1'b1,1'b0,1'b0,1'b1,5'd7,5'd6,1'b1,4'd1,4'd0});
    // branch together with stall: branch wins
    step('{1'b0,1'b1,1'b1,1'b1,1'b1,32'h1000,I4,1'b0,1'b0,1'b1,5'd8},
         '{32'h1000,32'h0,32'h0,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,1'b0,4'd1,4'd1});
    // fetch at branch target
    step('{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,I4,1'b0,1'b0,1'b0,5'd0},
         '{32'h1004,I4,32'h1004,1'b1,1'b0,1'b0,1'b0,5'd0,5'd0,1'b0,4'd1,4'd1});
    // PC advances while IF/ID holds
    step('{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,I1,1'b0,1'b0,1'b1,5'd10},
         '{32'h1008,I4,32'h1004,1'b1,1'b0,1'b0,1'b1,5'd10,5'd10,1'b1,4'd1,4'd1});
    // IF/ID loads while PC holds
    step('{1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,I2,1'b0,1'b0,1'b1,5'd10},
         '{32'h1008,I2,32'h100C,1'b1,1'b0,1'b0,1'b1,5'd10,5'd10,1'b1,4'd1,4'd1});
    // redirect ignores PC_WriteEn = 0
    step('{1'b0,1'b0,1'b0,1'b0,1'b1,32'hFFFF_FFFC,I3,1'b0,1'b0,1'b1,5'd6},
         '{32'hFFFF_FFFC,32'h0,32'h0,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,1'b0,
           4'd1,4'd2});
    // PC wrap: 0xFFFF_FFFC + 4 = 0
    step('{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,I3,1'b0,1'b0,1'b0,5'd0},
         '{32'h0,I3,32'h0,1'b1,1'b0,1'b0,1'b0,5'd0,5'd0,1'b0,4'd1,4'd2});
    // reset asserted mid-stall
    step('{1'b1,1'b0,1'b0,1'b1,1'b0,32'h0,I4,1'b0,1'b0,1'b1,5'd8}, rst_e);
    // 20 stall cycles: Stall_count saturates at 15
    for (int i = 1; i <= 20; i++) begin
      e    = rst_e;
      e.sc = (i > 15) ? 4'd15 : 4'(i);
      step('{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,I1,1'b0,1'b0,1'b0,5'd0}, e);
    end
    // normal advance after saturation
    step('{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,I1,1'b0,1'b0,1'b0,5'd0},
         '{32'h404,I1,32'h404,1'b1,1'b0,1'b0,1'b0,5'd0,5'd0,1'b0,4'd15,4'd0});

    repeat (3) @(posedge clk);
    #2;
    n_tot++;
    if (q.size() != 0)
      $display("FAIL drain: got %0d pending want 0", q.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
